// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the sequence-detector benches.
package seq_pkg;

    localparam int unsigned SEQ_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/seq_bit_counter.sv
// Bit position counter: counts 0..WIDTH-1 with a registered terminal-count flag.
module seq_bit_counter
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_DEFAULT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] count_q, count_d;
    logic          tc_q, tc_d;

    // Load restarts at bit 0; enable advances and wraps after the last bit.
    always_comb begin
        count_d = count_q;
        tc_d    = tc_q;
        if (load_i) begin
            count_d = '0;
            tc_d    = 1'b0;
        end else if (en_i) begin
            if (tc_q) begin
                count_d = '0;
                tc_d    = 1'b0;
            end else begin
                count_d = count_q + CW'(1);
                tc_d    = (count_q == CW'(WIDTH - 2));
            end
        end
    end

    // Counter and terminal-count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with one shift register and one pending buffer.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH      = SEQ_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] shifted_c;
    logic             cnt_load_c;
    logic             xfer_c;
    logic             last_bit;
    logic             out_bit_c;

    seq_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (cnt_load_c),
        .en_i   (state_q == SHIFT),
        .tc_o   (last_bit)
    );

    assign xfer_c    = data_valid && data_ready;
    assign shifted_c = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_q[WIDTH-1:1]};

    // Next-state: load shifter when empty or finishing, otherwise park in pending.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    shift_d    = data_in;
                    state_d    = SHIFT;
                    cnt_load_c = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_d = shifted_c;
                    if (xfer_c) begin
                        pend_d      = data_in;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    shift_d    = pend_q;
                    cnt_load_c = 1'b1;
                    if (xfer_c) begin
                        pend_d = data_in;
                    end else begin
                        pend_full_d = 1'b0;
                    end
                end else if (xfer_c) begin
                    shift_d    = data_in;
                    cnt_load_c = 1'b1;
                end else begin
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign out_bit_c    = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign serial_valid = (state_q == SHIFT);
    assign sequence_out = serial_valid ? out_bit_c : IDLE_LEVEL;
    assign word_done    = serial_valid && last_bit;
    assign busy         = serial_valid || pend_full_q;
    assign data_ready   = !pend_full_q && !reset;

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized bench for seq_serializer against a word-queue reference model.
module tb_seq_serializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         data_valid;
    logic [W-1:0] data_in;

    logic rdy_m, so_m, sv_m, wd_m, bz_m;
    logic rdy_l, so_l, sv_l, wd_l, bz_l;

    int unsigned  n_vec;
    int unsigned  n_err;

    // Reference: words accepted but not fully sent, and bit index within the head word.
    logic [W-1:0] m_q[$];
    int           m_pos;
    // Producer backlog.
    logic [W-1:0] tx_q[$];
    bit           vld_rand;

    seq_serializer #(
        .WIDTH      (W),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_dut_msb (
        .clock        (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (rdy_m),
        .sequence_out (so_m),
        .serial_valid (sv_m),
        .word_done    (wd_m),
        .busy         (bz_m)
    );

    seq_serializer #(
        .WIDTH      (W),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) u_dut_lsb (
        .clock        (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (rdy_l),
        .sequence_out (so_l),
        .serial_valid (sv_l),
        .word_done    (wd_l),
        .busy         (bz_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input bit rst);
        return !rst && (m_q.size() < 2);
    endfunction

    task automatic check_outputs(input bit rst);
        bit           act;
        logic [W-1:0] w;
        bit           b_m;
        bit           b_l;
        bit           last;
        act  = (m_q.size() > 0);
        b_m  = 1'b0;
        b_l  = 1'b0;
        last = 1'b0;
        if (act) begin
            w    = m_q[0];
            b_m  = w[W-1-m_pos];
            b_l  = w[m_pos];
            last = (m_pos == int'(W) - 1);
        end
        chk("ready_msb", 32'(rdy_m), 32'(exp_ready(rst)));
        chk("bit_msb",   32'(so_m),  32'(b_m));
        chk("valid_msb", 32'(sv_m),  32'(act));
        chk("done_msb",  32'(wd_m),  32'(last));
        chk("busy_msb",  32'(bz_m),  32'(act));
        chk("ready_lsb", 32'(rdy_l), 32'(exp_ready(rst)));
        chk("bit_lsb",   32'(so_l),  32'(b_l));
        chk("valid_lsb", 32'(sv_l),  32'(act));
        chk("done_lsb",  32'(wd_l),  32'(last));
        chk("busy_lsb",  32'(bz_l),  32'(act));
    endtask

    task automatic model_edge(input bit rst, input bit xfer, input logic [W-1:0] d);
        if (rst) begin
            m_q.delete();
            m_pos = 0;
        end else begin
            if (m_q.size() > 0) begin
                m_pos++;
                if (m_pos == int'(W)) begin
                    void'(m_q.pop_front());
                    m_pos = 0;
                end
            end
            if (xfer) m_q.push_back(d);
        end
    endtask

    // One clock: drive inputs, check outputs on the falling edge, advance the model on the rising edge.
    task automatic step(input bit rst);
        bit           v;
        bit           rdy;
        bit           xfer;
        logic [W-1:0] d;
        rdy = exp_ready(rst);
        if (rst) v = 1'b1;
        else     v = (tx_q.size() > 0) && (!vld_rand || ($urandom_range(0, 3) != 0));
        if (v && rdy && !rst) d = tx_q[0];
        else                  d = W'($urandom);
        reset      = rst;
        data_valid = v;
        data_in    = d;
        @(negedge clk);
        check_outputs(rst);
        xfer = v && rdy;
        @(posedge clk);
        model_edge(rst, xfer, d);
        if (xfer) void'(tx_q.pop_front());
        #1;
    endtask

    task automatic run_until_idle(input int limit);
        for (int n = 0; n < limit && (tx_q.size() > 0 || m_q.size() > 0); n++) step(1'b0);
        if (tx_q.size() > 0 || m_q.size() > 0) chk("drain_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_pos      = 0;
        vld_rand   = 1'b0;
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h5A;
        @(posedge clk);
        #1;

        // Reset held with valid high: nothing captured.
        step(1'b1);
        step(1'b1);

        // Single word, then a held-valid stream through the pending buffer.
        tx_q.push_back(8'hB4);
        run_until_idle(40);
        tx_q = {8'hB4, 8'h2D, 8'h0D, 8'h96};
        run_until_idle(80);

        // Reset on the third bit of 8'hFF while 8'hAA waits in pending.
        tx_q = {8'hFF, 8'hAA};
        for (int n = 0; n < 20 && !(m_q.size() == 2 && m_pos == 2); n++) step(1'b0);
        if (!(m_q.size() == 2 && m_pos == 2)) chk("midword_setup_timeout", 32'(1), 32'(0));
        step(1'b1);
        tx_q.delete();
        repeat (4) step(1'b0);

        // Random traffic with gaps, data churn while stalled and sporadic resets.
        vld_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (tx_q.size() < 3) tx_q.push_back(W'($urandom));
            step($urandom_range(0, 99) == 0);
        end
        vld_rand = 1'b0;
        run_until_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
